// File: rtl/tdc_stimulus_gen_if.sv
// Purpose : bus bundle between a calibration/self-test controller and the TDC
//           stimulus generator.
// Signals :
//   cfg_valid/cfg_ready       configuration handshake
//   cfg_delay/cfg_gap         start->stop and stop->next-start intervals (cycles)
//   cfg_burst                 number of start/stop pairs (0 means 1)
//   abort                     synchronous cancel of the running burst
//   start/stop                pulses routed to the TDC
//   busy/done/shot_count      status back to the controller
// Modports: master = controller side, slave = generator side.
interface tdc_stimulus_gen_if #(
  parameter int DELAY_W = 16,
  parameter int BURST_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [DELAY_W-1:0] cfg_delay;
  logic [DELAY_W-1:0] cfg_gap;
  logic [BURST_W-1:0] cfg_burst;
  logic               abort;
  logic               start;
  logic               stop;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] shot_count;

  modport master (
    output cfg_valid, cfg_delay, cfg_gap, cfg_burst, abort,
    input  cfg_ready, start, stop, busy, done, shot_count
  );

  modport slave (
    input  cfg_valid, cfg_delay, cfg_gap, cfg_burst, abort,
    output cfg_ready, start, stop, busy, done, shot_count
  );
endinterface

// File: rtl/tdc_stimulus_gen.sv
// Purpose : transmitter side of the TDC start/stop interface. Emits a start
//           pulse, then a stop pulse a programmed number of cycles later,
//           optionally repeated as a burst. Used for TDC calibration/self-test.
// Ports   :
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   tdc_stimulus_gen_if.slave (config handshake, abort, start/stop, status)
// Parameters:
//   DELAY_W   width of the interval fields and of the interval counter
//   BURST_W   width of cfg_burst and shot_count
//   PULSE_LEN start/stop high time in cycles
module tdc_stimulus_gen #(
  parameter int DELAY_W   = 16,
  parameter int BURST_W   = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  tdc_stimulus_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_HI  = 3'd1,
    S_WAIT_STOP = 3'd2,
    S_STOP_HI   = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  localparam logic [DELAY_W-1:0] PULSE_V  = DELAY_W'(PULSE_LEN);
  // Shortest legal interval: a pulse must have fallen before the other one rises.
  localparam logic [DELAY_W-1:0] MIN_IV   = DELAY_W'(PULSE_LEN + 1);
  localparam logic [DELAY_W-1:0] CNT_ONE  = DELAY_W'(1);
  localparam logic [BURST_W-1:0] SHOT_ONE = BURST_W'(1);
  localparam logic [BURST_W-1:0] SHOT_MAX = {BURST_W{1'b1}};

  function automatic logic [DELAY_W-1:0] clamp_iv(input logic [DELAY_W-1:0] v);
    if (v < MIN_IV) begin
      return MIN_IV;
    end else begin
      return v;
    end
  endfunction

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [DELAY_W-1:0] gap_q, gap_d;
  logic [BURST_W-1:0] num_q, num_d;
  logic [BURST_W-1:0] shot_q, shot_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic cfg_ready_s;
  logic accept_s;
  logic abort_s;
  logic cnt_pulse_end_s;

  assign cfg_ready_s     = (state_q == S_IDLE) && !bus.abort;
  assign accept_s        = bus.cfg_valid && cfg_ready_s;
  assign abort_s         = bus.abort && busy_q;
  // The counter holds 1 in the cycle after a rise, so it equals PULSE_LEN in
  // the last high cycle of a pulse.
  assign cnt_pulse_end_s = (cnt_q == PULSE_V);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      gap_q   <= '0;
      num_q   <= '0;
      shot_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      gap_q   <= gap_d;
      num_q   <= num_d;
      shot_q  <= shot_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Accept goes through GAP with the counter preloaded to the gap value,
      // so start rises exactly one edge after the accept edge.
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START_HI: begin
        if (cnt_pulse_end_s) begin
          state_d = S_WAIT_STOP;
        end else begin
          state_d = S_START_HI;
        end
      end
      S_WAIT_STOP: begin
        if (cnt_q == delay_q) begin
          state_d = S_STOP_HI;
        end else begin
          state_d = S_WAIT_STOP;
        end
      end
      S_STOP_HI: begin
        if (cnt_pulse_end_s) begin
          if (shot_q >= num_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          state_d = S_STOP_HI;
        end
      end
      S_GAP: begin
        if (cnt_q == gap_q) begin
          state_d = S_START_HI;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Output and datapath next values
  always_comb begin
    cnt_d   = cnt_q + CNT_ONE;
    delay_d = delay_q;
    gap_d   = gap_q;
    num_d   = num_q;
    shot_d  = shot_q;
    start_d = start_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (accept_s) begin
          delay_d = clamp_iv(bus.cfg_delay);
          gap_d   = clamp_iv(bus.cfg_gap);
          num_d   = (bus.cfg_burst == '0) ? SHOT_ONE : bus.cfg_burst;
          cnt_d   = clamp_iv(bus.cfg_gap);
          shot_d  = '0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_START_HI: begin
        if (cnt_pulse_end_s) begin
          start_d = 1'b0;
        end else begin
          start_d = 1'b1;
        end
      end
      S_WAIT_STOP: begin
        if (cnt_q == delay_q) begin
          stop_d = 1'b1;
          cnt_d  = CNT_ONE;
          shot_d = (shot_q == SHOT_MAX) ? SHOT_MAX : (shot_q + SHOT_ONE);
        end else begin
          stop_d = 1'b0;
        end
      end
      S_STOP_HI: begin
        if (cnt_pulse_end_s) begin
          stop_d = 1'b0;
          if (shot_q >= num_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end else begin
          stop_d = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == gap_q) begin
          start_d = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          start_d = 1'b0;
        end
      end
      default: begin
        start_d = 1'b0;
        stop_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // Abort drops the pulses immediately; an in-flight start is left orphaned
    // and shot_count keeps the number of stops already issued.
    if (abort_s) begin
      start_d = 1'b0;
      stop_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      shot_d  = shot_q;
    end else begin
      done_d  = done_d;
    end
  end

  assign bus.cfg_ready  = cfg_ready_s;
  assign bus.start      = start_q;
  assign bus.stop       = stop_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.shot_count = shot_q;

endmodule

// File: tb/tb_tdc_stimulus_gen.sv
// Purpose : directed self-checking bench for tdc_stimulus_gen (PULSE_LEN=4).
//           Cycle index k counts sampling points after the accept edge E
//           (k=0 is just after E); outputs are sampled on the falling edge.
module tb_tdc_stimulus_gen;
  localparam int DW = 16;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tdc_stimulus_gen_if #(.DELAY_W(DW), .BURST_W(BW)) bus ();

  tdc_stimulus_gen #(.DELAY_W(DW), .BURST_W(BW), .PULSE_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int st_r[$], st_f[$], sp_r[$], sp_f[$];
  int done_k, ovl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one configuration, lets it be accepted, and returns at k=0.
  task automatic accept(input int d, input int g, input int b, input bit keep_valid);
    @(negedge clk);
    bus.cfg_delay = DW'(d);
    bus.cfg_gap   = DW'(g);
    bus.cfg_burst = BW'(b);
    bus.cfg_valid = 1'b1;
    chk("ready_before_accept", bus.cfg_ready, 1);
    @(negedge clk);
    if (!keep_valid) bus.cfg_valid = 1'b0;
    chk("busy_k0", bus.busy, 1);
    chk("start_k0", bus.start, 0);
    chk("shot_k0", bus.shot_count, 0);
  endtask

  // Records rise/fall cycles of start/stop until done or the cycle budget ends.
  task automatic capture(input int max_cyc);
    logic ps, pp;
    st_r.delete(); st_f.delete(); sp_r.delete(); sp_f.delete();
    done_k = -1;
    ovl    = 0;
    ps     = bus.start;
    pp     = bus.stop;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (bus.start && !ps) st_r.push_back(k);
      if (!bus.start && ps) st_f.push_back(k);
      if (bus.stop && !pp)  sp_r.push_back(k);
      if (!bus.stop && pp)  sp_f.push_back(k);
      if (bus.start && bus.stop) ovl++;
      ps = bus.start;
      pp = bus.stop;
      if (bus.done) begin
        done_k = k;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    bus.cfg_valid = 1'b0;
    bus.cfg_delay = '0;
    bus.cfg_gap   = '0;
    bus.cfg_burst = '0;
    bus.abort     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_start", bus.start, 0);
    chk("rst_stop", bus.stop, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_shot", bus.shot_count, 0);
    chk("rst_ready", bus.cfg_ready, 1);
    rst = 1'b0;

    // Single shot, delay 10
    accept(10, 0, 1, 1'b0);
    capture(40);
    chk("t1_start_rise", (st_r.size() > 0) ? st_r[0] : -1, 1);
    chk("t1_start_fall", (st_f.size() > 0) ? st_f[0] : -1, 5);
    chk("t1_stop_rise", (sp_r.size() > 0) ? sp_r[0] : -1, 11);
    chk("t1_stop_fall", (sp_f.size() > 0) ? sp_f[0] : -1, 15);
    chk("t1_done", done_k, 15);
    chk("t1_shot", bus.shot_count, 1);
    chk("t1_busy_in_done", bus.busy, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", bus.done, 0);
    chk("t1_ready_after", bus.cfg_ready, 1);

    // Burst of 3, delay 10, gap 20 (gap measured stop rise -> next start rise)
    accept(10, 20, 3, 1'b0);
    capture(120);
    chk("t2_n_start", st_r.size(), 3);
    chk("t2_n_stop", sp_r.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_start_rise", (i < st_r.size()) ? st_r[i] : -1, 1 + 30 * i);
      chk("t2_stop_rise", (i < sp_r.size()) ? sp_r[i] : -1, 11 + 30 * i);
    end
    chk("t2_done", done_k, 75);
    chk("t2_shot", bus.shot_count, 3);
    chk("t2_overlap", ovl, 0);

    // Clamped intervals: delay 2 -> 5, burst 0 -> 1
    accept(2, 0, 0, 1'b0);
    capture(40);
    chk("t3_start_rise", (st_r.size() > 0) ? st_r[0] : -1, 1);
    chk("t3_start_fall", (st_f.size() > 0) ? st_f[0] : -1, 5);
    chk("t3_stop_rise", (sp_r.size() > 0) ? sp_r[0] : -1, 6);
    chk("t3_n_stop", sp_r.size(), 1);
    chk("t3_done", done_k, 10);
    chk("t3_shot", bus.shot_count, 1);

    // cfg_valid held high through a burst of 2 (delay 6, gap 6)
    accept(6, 6, 2, 1'b1);
    capture(60);
    chk("t4_n_start", st_r.size(), 2);
    chk("t4_start2", (st_r.size() > 1) ? st_r[1] : -1, 13);
    chk("t4_stop2", (sp_r.size() > 1) ? sp_r[1] : -1, 19);
    chk("t4_done", done_k, 23);
    chk("t4_overlap", ovl, 0);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("t4_reaccept_busy", bus.busy, 1);
    chk("t4_reaccept_shot", bus.shot_count, 0);
    chk("t4_reaccept_start_low", bus.start, 0);
    @(negedge clk);
    chk("t4_second_start", bus.start, 1);
    seen_done = 0;
    for (int k = 0; k < 60 && seen_done == 0; k++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1;
    end
    chk("t4_second_done", seen_done, 1);
    chk("t4_second_shot", bus.shot_count, 2);

    // Abort 3 cycles after the first stop rise of a burst of 4
    accept(10, 10, 4, 1'b0);
    repeat (13) @(negedge clk);
    chk("t5_stop_before_abort", bus.stop, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    chk("t5_start", bus.start, 0);
    chk("t5_stop", bus.stop, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_shot", bus.shot_count, 1);
    chk("t5_ready_while_abort", bus.cfg_ready, 0);
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t5_no_late_done", bus.done, 0);
    chk("t5_ready_after", bus.cfg_ready, 1);
    chk("t5_shot_held", bus.shot_count, 1);

    // Reset in WAIT_STOP, then a normal run
    accept(20, 0, 1, 1'b0);
    repeat (8) @(negedge clk);
    chk("t6_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_start", bus.start, 0);
    chk("t6_stop", bus.stop, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_shot", bus.shot_count, 0);
    chk("t6_ready", bus.cfg_ready, 1);
    accept(7, 0, 1, 1'b0);
    capture(40);
    chk("t7_start_rise", (st_r.size() > 0) ? st_r[0] : -1, 1);
    chk("t7_stop_rise", (sp_r.size() > 0) ? sp_r[0] : -1, 8);
    chk("t7_done", done_k, 12);
    chk("t7_shot", bus.shot_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
